// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the beamformer result UART transmitter.
package uart_tx_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP_BIT  = 3'd4,
        GUARD     = 3'd5
    } tx_state_e;

    // Integer clocks per bit; the fractional part is dropped.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running and flags the last clock of each bit.
module uart_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick marks the final clock of the current bit; the counter wraps on it.
    always_comb begin
        cnt_d  = cnt_q;
        tick_c = run && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            if (tick_c) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_communication.sv
// 8N1 UART transmitter for beamformer RAM read-out, with a post-frame guard gap.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module uart_tx_communication
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned BAUD_RATE    = 115_200,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                 CLOCK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [DATA_BITS-1:0] SW,
    output logic                 UART_TXD,
    output logic                 TX_BUSY_REG
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned BIT_CNT_W    = $clog2(DATA_BITS);
    localparam int unsigned GUARD_W      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    tx_state_e              state_q;
    tx_state_e              state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_d;
    logic [GUARD_W-1:0]     guard_cnt_q;
    logic [GUARD_W-1:0]     guard_cnt_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic                   txd_q;
    logic                   txd_d;
    logic                   busy_q;
    logic                   busy_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
    logic                   parity_d;
`endif

    logic                   frame_start_c;
    logic                   baud_run_c;
    logic                   bit_tick_c;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (CLOCK),
        .rst_n  (RESET_N),
        .clear  (frame_start_c),
        .run    (baud_run_c),
        .tick_c (bit_tick_c)
    );

    // Next-state and registered-output logic; the line value for a bit is loaded on the edge that starts it.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        guard_cnt_d   = guard_cnt_q;
        shift_d       = shift_q;
        txd_d         = txd_q;
        busy_d        = busy_q;
        frame_start_c = 1'b0;
        baud_run_c    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d      = parity_q;
`endif

        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (START && !STOP) begin
                    frame_start_c = 1'b1;
                    shift_d       = SW;
                    bit_cnt_d     = '0;
                    txd_d         = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = START_BIT;
`ifdef UART_TX_PARITY_EN
                    parity_d      = ^SW;
`endif
                end
            end

            START_BIT: begin
                baud_run_c = 1'b1;
                if (bit_tick_c) begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end
            end

            DATA: begin
                baud_run_c = 1'b1;
                if (bit_tick_c) begin
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP_BIT;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end

            PARITY: begin
                baud_run_c = 1'b1;
                if (bit_tick_c) begin
                    txd_d   = 1'b1;
                    state_d = STOP_BIT;
                end
            end

            STOP_BIT: begin
                baud_run_c = 1'b1;
                if (bit_tick_c) begin
                    txd_d       = 1'b1;
                    busy_d      = 1'b0;
                    guard_cnt_d = '0;
                    state_d     = GUARD;
                end
            end

            // Quiet gap that lets the upstream RAM read and mux settle before START is honoured.
            GUARD: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (guard_cnt_q == GUARD_W'(GUARD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end

            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            guard_cnt_q <= '0;
            shift_q     <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign UART_TXD    = txd_q;
    assign TX_BUSY_REG = busy_q;

endmodule

// File: tb/tb_uart_tx_communication.sv
// Self-checking bench for uart_tx_communication: frames are compared against a bit-list model built from the byte.
module tb_uart_tx_communication;

    localparam int CPB   = 10;
    localparam int GUARD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB    = 11;
`else
    localparam int NB    = 10;
`endif

    logic       CLOCK;
    logic       RESET_N;
    logic       START;
    logic       STOP;
    logic [7:0] SW;
    logic       UART_TXD;
    logic       TX_BUSY_REG;

    int total;
    int bad;

    uart_tx_communication #(
        .CLK_FREQ_HZ  (100),
        .BAUD_RATE    (10),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .START       (START),
        .STOP        (STOP),
        .SW          (SW),
        .UART_TXD    (UART_TXD),
        .TX_BUSY_REG (TX_BUSY_REG)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a frame, records the line once per clock while busy, and compares with the expected bit list.
    task automatic expect_frame(input string tag, input logic [7:0] data, input int stop_at);
        logic       exp_bits[$];
        logic       samples[$];
        logic [7:0] rx;
        int         w;
        int         n;
        int         hits;
        int         idx;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back(^data);
`endif
        exp_bits.push_back(1'b1);

        w = 0;
        while (TX_BUSY_REG !== 1'b1 && w < 200) begin
            @(negedge CLOCK);
            w++;
        end
        if (TX_BUSY_REG !== 1'b1) begin
            check_eq({tag, "_start_timeout"}, 64'(TX_BUSY_REG), 64'd1);
            return;
        end

        n = 0;
        while (TX_BUSY_REG === 1'b1 && n < 2 * NB * CPB) begin
            samples.push_back(UART_TXD);
            @(negedge CLOCK);
            n++;
            if (n == stop_at) STOP = 1'b1;
        end
        check_eq({tag, "_busy_len"}, 64'(n), 64'(NB * CPB));

        for (int b = 0; b < NB; b++) begin
            hits = 0;
            for (int k = 0; k < CPB; k++) begin
                idx = b * CPB + k;
                if (idx < samples.size() && samples[idx] === exp_bits[b]) hits++;
            end
            check_eq($sformatf("%s_bit%0d", tag, b), 64'(hits), 64'(CPB));
        end

        for (int i = 0; i < 8; i++) begin
            idx = (i + 1) * CPB + CPB / 2;
            rx[i] = (idx < samples.size()) ? samples[idx] : 1'bx;
        end
        check_eq({tag, "_byte"}, 64'(rx), 64'(data));
        check_eq({tag, "_line_after"}, 64'(UART_TXD), 64'd1);
    endtask

    // Called on the first clock with busy low; measures the idle gap and presents the next byte one clock in.
    task automatic measure_gap(input string tag, input logic [7:0] nxt);
        int   gap;
        logic ok;
        gap = 0;
        ok  = 1'b1;
        while (TX_BUSY_REG === 1'b0 && gap < 50) begin
            ok = ok & UART_TXD;
            gap++;
            @(negedge CLOCK);
            if (gap == 1) SW = nxt;
        end
        check_eq({tag, "_gap"}, 64'(gap), 64'(GUARD + 1));
        check_eq({tag, "_gap_line"}, 64'(ok), 64'd1);
    endtask

    task automatic count_quiet(input string tag, input int cycles);
        int act;
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLOCK);
            if (TX_BUSY_REG !== 1'b0 || UART_TXD !== 1'b1) act++;
        end
        check_eq({tag, "_quiet"}, 64'(act), 64'd0);
    endtask

    task automatic pulse_frame(input string tag, input logic [7:0] data);
        @(negedge CLOCK);
        SW    = data;
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        check_eq({tag, "_lat_busy"}, 64'(TX_BUSY_REG), 64'd1);
        check_eq({tag, "_lat_txd"}, 64'(UART_TXD), 64'd0);
        expect_frame(tag, data, -1);
        repeat (GUARD + 2) @(negedge CLOCK);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] word;
        logic [7:0]  exp_order [5];
        logic [7:0]  d;
        int          falls;

        total   = 0;
        bad     = 0;
        RESET_N = 1'b0;
        START   = 1'b0;
        STOP    = 1'b0;
        SW      = 8'h00;
        repeat (3) @(negedge CLOCK);
        check_eq("reset_txd", 64'(UART_TXD), 64'd1);
        check_eq("reset_busy", 64'(TX_BUSY_REG), 64'd0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK);

        pulse_frame("a5", 8'hA5);
        pulse_frame("p07", 8'h07);
        for (int r = 0; r < 4; r++) begin
            d = 8'($urandom);
            pulse_frame($sformatf("rnd%0d", r), d);
        end

        // START raised in the guard window must not launch a frame.
        @(negedge CLOCK);
        SW    = 8'($urandom);
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        expect_frame("gchk", SW, -1);
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        count_quiet("guard_ignore", 20);

        // Asynchronous reset in the middle of a frame.
        @(negedge CLOCK);
        SW    = 8'h00;
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        repeat (35) @(negedge CLOCK);
        #2;
        RESET_N = 1'b0;
        #1;
        check_eq("midrst_txd", 64'(UART_TXD), 64'd1);
        check_eq("midrst_busy", 64'(TX_BUSY_REG), 64'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        count_quiet("after_rst", 30);

        // Back-to-back with START held; SW changes one clock after busy falls.
        d     = 8'($urandom);
        SW    = d;
        START = 1'b1;
        expect_frame("held1", d, -1);
        measure_gap("held", 8'h3C);
        expect_frame("held2", 8'h3C, -1);
        START = 1'b0;
        repeat (GUARD + 4) @(negedge CLOCK);

        // STOP raised mid-frame: frame completes, then nothing while STOP holds with START.
        d     = 8'($urandom);
        SW    = d;
        START = 1'b1;
        expect_frame("stopmid", d, 30);
        count_quiet("stop_wins", 200);
        START = 1'b0;
        @(negedge CLOCK);
        STOP = 1'b0;
        repeat (3) @(negedge CLOCK);

        // Read-out loop: byte index advances on each busy fall.
        word         = 40'h0123456789;
        exp_order[0] = 8'h89;
        exp_order[1] = 8'h67;
        exp_order[2] = 8'h45;
        exp_order[3] = 8'h23;
        exp_order[4] = 8'h01;
        falls        = 0;
        SW           = word[7:0];
        START        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_frame($sformatf("word_b%0d", i), exp_order[i], -1);
            falls++;
            if (falls == 5) begin
                START = 1'b0;
            end else begin
                measure_gap($sformatf("word_g%0d", i), word[8 * falls +: 8]);
            end
        end
        count_quiet("word_end", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
